// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage.
// Holds the load/store opcode constants, the data-memory controller state
// type and the access-size type used by the byte-lane unit.
package mips_pkg;

  // Store opcodes (INSTR[31:26])
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;
  // Load opcodes
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;

  // CLEAR: post-reset zeroing sweep; RUN: normal pipeline service
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } dmem_state_t;

  // Access size of a load or store
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } dm_size_t;

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane steering for the data memory (purely combinational).
// Ports:
//   size       - access size (byte / half / word)
//   is_signed  - sign-extend the load result (lb/lh) instead of zero-extend
//   addr_lo    - byte offset within the word (address bits [1:0])
//   store_data - rt value of the store
//   raw_word   - current contents of the addressed memory word
//   byte_en    - per-byte write enables, little-endian (bit k = bits [8k+7:8k])
//   wr_data    - store data replicated across all lanes
//   load_data  - selected byte/half/word, extended to 32 bits
module dm_lane_unit
  import mips_pkg::*;
(
  input  dm_size_t    size,
  input  logic        is_signed,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_data,
  output logic [31:0] load_data
);

  logic [7:0]  lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = raw_word[8*gi +: 8];
  end

  assign sel_byte = lane[addr_lo];
  assign sel_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

  // Store side: data is replicated so the enables alone pick the target lane
  always_comb begin
    byte_en = 4'b0000;
    wr_data = 32'h0;
    case (size)
      SZ_W: begin
        byte_en = 4'b1111;
        wr_data = store_data;
      end
      SZ_H: begin
        byte_en = 4'b0011 << {addr_lo[1], 1'b0};
        wr_data = {2{store_data[15:0]}};
      end
      SZ_B: begin
        byte_en = 4'b0001 << addr_lo;
        wr_data = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

  // Load side
  always_comb begin
    load_data = 32'h0;
    case (size)
      SZ_W: load_data = raw_word;
      SZ_H: load_data = {{16{is_signed & sel_half[15]}}, sel_half};
      SZ_B: load_data = {{24{is_signed & sel_byte[7]}}, sel_byte};
      default: ;
    endcase
  end

endmodule

// File: rtl/m_dmem_unit.sv
// Memory-stage data memory of the 5-stage MIPS pipeline.
// Performs lw/lh/lhu/lb/lbu loads and sw/sh/sb stores against an internal
// word array. After reset a clear sweep zeroes every word while BUSY_M holds
// the pipeline.
// Ports:
//   clk      - clock, all state updates on posedge
//   reset    - asynchronous active-high reset (restarts the clear sweep)
//   INSTR_M  - M-stage instruction, opcode in [31:26]
//   ALUOUT_M - byte address
//   A2_M     - store data (rt)
//   PC4_M    - PC+4 of the M-stage instruction (store trace only)
//   RD_M     - extended load result, 0 for non-loads / exceptions / CLEAR
//   BUSY_M   - high while the clear sweep runs
//   ADEXC_M  - misaligned or out-of-range load/store
// Optional build macro: DM_TRACE_EN prints one line per committed store.
module m_dmem_unit
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int IDX_W       = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] INSTR_M,
  input  logic [31:0] ALUOUT_M,
  input  logic [31:0] A2_M,
  input  logic [31:0] PC4_M,
  output logic [31:0] RD_M,
  output logic        BUSY_M,
  output logic        ADEXC_M
);

  localparam logic [31:0]      ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [IDX_W:0]   DEPTH_EXT  = (IDX_W + 1)'(DEPTH_WORDS);

  dmem_state_t      state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             busy_q, busy_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [5:0]       opcode;
  logic             is_load, is_store, is_signed;
  dm_size_t         size;
  logic [IDX_W-1:0] word_idx;
  logic             misaligned, out_of_range, addr_exc;
  logic [31:0]      raw_word, wr_data, load_data, merged_word;
  logic [3:0]       byte_en;

  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;

  // Instruction bits below the opcode and (without tracing) PC4_M are not needed
  logic unused_ok;
  assign unused_ok = ^{INSTR_M[25:0], PC4_M};

  assign opcode   = INSTR_M[31:26];
  assign word_idx = ALUOUT_M[IDX_W+1:2];

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SZ_W;
    case (opcode)
      OP_SW:  begin is_store = 1'b1; size = SZ_W; end
      OP_SH:  begin is_store = 1'b1; size = SZ_H; end
      OP_SB:  begin is_store = 1'b1; size = SZ_B; end
      OP_LW:  begin is_load  = 1'b1; size = SZ_W; end
      OP_LH:  begin is_load  = 1'b1; size = SZ_H; is_signed = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; size = SZ_H; end
      OP_LB:  begin is_load  = 1'b1; size = SZ_B; is_signed = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; size = SZ_B; end
      default: ;
    endcase
  end

  always_comb begin
    misaligned   = ((size == SZ_W) && (ALUOUT_M[1:0] != 2'b00)) ||
                   ((size == SZ_H) && ALUOUT_M[0]);
    out_of_range = (ALUOUT_M >= ADDR_LIMIT);
    addr_exc     = (state_q == RUN) && (is_load || is_store) &&
                   (misaligned || out_of_range);
  end

  // Asynchronous read; an index past the array (only reachable when the
  // access is already flagged out of range) reads as zero.
  assign raw_word = ({1'b0, word_idx} < DEPTH_EXT) ? mem_q[word_idx] : 32'h0;

  dm_lane_unit u_lane (
    .size       (size),
    .is_signed  (is_signed),
    .addr_lo    (ALUOUT_M[1:0]),
    .store_data (A2_M),
    .raw_word   (raw_word),
    .byte_en    (byte_en),
    .wr_data    (wr_data),
    .load_data  (load_data)
  );

  // Read-modify-write merge: the array is written a full word at a time
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_word[8*gi +: 8] = byte_en[gi] ? wr_data[8*gi +: 8]
                                                : raw_word[8*gi +: 8];
  end

  // FSM, clear counter and array write port
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_wdata = merged_word;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = clr_idx_q;
        mem_wdata = 32'h0;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = RUN;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      RUN: begin
        mem_we = is_store && !addr_exc;
      end
      default: state_d = CLEAR;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  assign BUSY_M  = busy_q;
  assign ADEXC_M = addr_exc;
  assign RD_M    = ((state_q == RUN) && is_load && !addr_exc) ? load_data : 32'h0;

`ifdef DM_TRACE_EN
  always @(posedge clk) begin
    if ((state_q == RUN) && is_store && !addr_exc) begin
      $display("%d@%h: *%h <= %h", $time, PC4_M - 32'd4,
               {ALUOUT_M[31:2], 2'b00}, merged_word);
    end
  end
`endif

endmodule

// File: tb/tb_m_dmem_unit.sv
// Directed testbench for m_dmem_unit: clear sweep timing, load extension,
// store merging, address exceptions, mid-sweep reset and the trace store.
module tb_m_dmem_unit;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] INSTR_M;
  logic [31:0] ALUOUT_M;
  logic [31:0] A2_M;
  logic [31:0] PC4_M;
  logic [31:0] RD_M;
  logic        BUSY_M;
  logic        ADEXC_M;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] OP_NOP = 6'h00;

  m_dmem_unit dut (
    .clk      (clk),
    .reset    (reset),
    .INSTR_M  (INSTR_M),
    .ALUOUT_M (ALUOUT_M),
    .A2_M     (A2_M),
    .PC4_M    (PC4_M),
    .RD_M     (RD_M),
    .BUSY_M   (BUSY_M),
    .ADEXC_M  (ADEXC_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operation at the falling edge; outputs are settled #1 later.
  // A store commits on the following rising edge.
  task automatic drive(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] data);
    @(negedge clk);
    INSTR_M  = {op, 26'h0};
    ALUOUT_M = addr;
    A2_M     = data;
    #1;
    $display("txn op=%h addr=%h a2=%h rd=%h adexc=%b busy=%b",
             op, addr, data, RD_M, ADEXC_M, BUSY_M);
  endtask

  task automatic test_reset;
    int early_drop;
    reset    = 1'b1;
    INSTR_M  = {OP_LW, 26'h0};
    ALUOUT_M = 32'h6;
    A2_M     = 32'h0;
    PC4_M    = 32'h1004;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (BUSY_M !== 1'b1 || RD_M !== 32'h0 || ADEXC_M !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: busy=%b rd=%h adexc=%b expected busy=1 rd=00000000 adexc=0",
                 BUSY_M, RD_M, ADEXC_M);
      end
    end
    reset   = 1'b0;
    INSTR_M = {OP_NOP, 26'h0};
    early_drop = 0;
    for (int i = 1; i <= 3072; i++) begin
      @(posedge clk);
      #1;
      if (i < 3072 && BUSY_M !== 1'b1) early_drop++;
      if (i == 3072) begin
        n_checks++;
        if (BUSY_M !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_end: busy=%b expected 0 at cycle 3072", BUSY_M);
        end
      end
    end
    n_checks++;
    if (early_drop != 0) begin
      n_fail++;
      $display("FAIL sweep_hold: busy low in %0d cycles expected 0", early_drop);
    end
    drive(OP_LW, 32'h2FFC, 32'h0);
    n_checks++;
    if (RD_M !== 32'h0 || ADEXC_M !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_2ffc_cleared: rd=%h adexc=%b expected 00000000 0", RD_M, ADEXC_M);
    end
  endtask

  task automatic test_load_ext;
    drive(OP_SW, 32'h10, 32'h12345678);
    drive(OP_LB, 32'h11, 32'h0);
    n_checks++;
    if (RD_M !== 32'h00000056) begin
      n_fail++;
      $display("FAIL lb_0011: rd=%h expected 00000056", RD_M);
    end
    drive(OP_LBU, 32'h13, 32'h0);
    n_checks++;
    if (RD_M !== 32'h00000012) begin
      n_fail++;
      $display("FAIL lbu_0013: rd=%h expected 00000012", RD_M);
    end
    drive(OP_LH, 32'h12, 32'h0);
    n_checks++;
    if (RD_M !== 32'h00001234) begin
      n_fail++;
      $display("FAIL lh_0012: rd=%h expected 00001234", RD_M);
    end
    drive(OP_LHU, 32'h10, 32'h0);
    n_checks++;
    if (RD_M !== 32'h00005678) begin
      n_fail++;
      $display("FAIL lhu_0010: rd=%h expected 00005678", RD_M);
    end
  endtask

  task automatic test_merge;
    drive(OP_SW, 32'h20, 32'h12345678);
    drive(OP_SB, 32'h21, 32'h000000AB);
    drive(OP_LW, 32'h20, 32'h0);
    n_checks++;
    if (RD_M !== 32'h1234AB78) begin
      n_fail++;
      $display("FAIL sb_merge: rd=%h expected 1234ab78", RD_M);
    end
    drive(OP_SH, 32'h22, 32'h0000CDEF);
    drive(OP_LW, 32'h20, 32'h0);
    n_checks++;
    if (RD_M !== 32'hCDEFAB78) begin
      n_fail++;
      $display("FAIL sh_merge: rd=%h expected cdefab78", RD_M);
    end
    drive(OP_LB, 32'h21, 32'h0);
    n_checks++;
    if (RD_M !== 32'hFFFFFFAB) begin
      n_fail++;
      $display("FAIL lb_sign: rd=%h expected ffffffab", RD_M);
    end
    drive(OP_LH, 32'h22, 32'h0);
    n_checks++;
    if (RD_M !== 32'hFFFFCDEF) begin
      n_fail++;
      $display("FAIL lh_sign: rd=%h expected ffffcdef", RD_M);
    end
    drive(OP_LHU, 32'h22, 32'h0);
    n_checks++;
    if (RD_M !== 32'h0000CDEF) begin
      n_fail++;
      $display("FAIL lhu_zero: rd=%h expected 0000cdef", RD_M);
    end
  endtask

  task automatic test_exceptions;
    drive(OP_SW, 32'h0, 32'h33334444);
    drive(OP_SW, 32'h4, 32'h11112222);
    drive(OP_SW, 32'h2FFC, 32'h55556666);
    drive(OP_LW, 32'h6, 32'h0);
    n_checks++;
    if (ADEXC_M !== 1'b1 || RD_M !== 32'h0) begin
      n_fail++;
      $display("FAIL lw_misaligned: adexc=%b rd=%h expected 1 00000000", ADEXC_M, RD_M);
    end
    drive(OP_SH, 32'h3, 32'h0000FFFF);
    n_checks++;
    if (ADEXC_M !== 1'b1 || RD_M !== 32'h0) begin
      n_fail++;
      $display("FAIL sh_misaligned: adexc=%b rd=%h expected 1 00000000", ADEXC_M, RD_M);
    end
    drive(OP_SW, 32'h3000, 32'hFFFFFFFF);
    n_checks++;
    if (ADEXC_M !== 1'b1 || RD_M !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_out_of_range: adexc=%b rd=%h expected 1 00000000", ADEXC_M, RD_M);
    end
    drive(OP_LBU, 32'h3000, 32'h0);
    n_checks++;
    if (ADEXC_M !== 1'b1 || RD_M !== 32'h0) begin
      n_fail++;
      $display("FAIL lbu_out_of_range: adexc=%b rd=%h expected 1 00000000", ADEXC_M, RD_M);
    end
    drive(OP_LW, 32'h0, 32'h0);
    n_checks++;
    if (RD_M !== 32'h33334444 || ADEXC_M !== 1'b0) begin
      n_fail++;
      $display("FAIL word0_unchanged: rd=%h adexc=%b expected 33334444 0", RD_M, ADEXC_M);
    end
    drive(OP_LW, 32'h4, 32'h0);
    n_checks++;
    if (RD_M !== 32'h11112222 || ADEXC_M !== 1'b0) begin
      n_fail++;
      $display("FAIL word1_unchanged: rd=%h adexc=%b expected 11112222 0", RD_M, ADEXC_M);
    end
    drive(OP_LW, 32'h2FFC, 32'h0);
    n_checks++;
    if (RD_M !== 32'h55556666 || ADEXC_M !== 1'b0) begin
      n_fail++;
      $display("FAIL last_word: rd=%h adexc=%b expected 55556666 0", RD_M, ADEXC_M);
    end
    drive(OP_NOP, 32'h3, 32'h0);
    n_checks++;
    if (RD_M !== 32'h0 || ADEXC_M !== 1'b0) begin
      n_fail++;
      $display("FAIL nonmem_op: rd=%h adexc=%b expected 00000000 0", RD_M, ADEXC_M);
    end
  endtask

  task automatic test_trace_store;
    PC4_M = 32'h3004;
    drive(OP_SW, 32'h40, 32'hDEADBEEF);
    PC4_M = 32'h1004;
    drive(OP_LW, 32'h40, 32'h0);
    n_checks++;
    if (RD_M !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL trace_sw: rd=%h expected deadbeef", RD_M);
    end
  endtask

  task automatic test_mid_sweep_reset;
    int early_drop;
    @(negedge clk);
    INSTR_M = {OP_NOP, 26'h0};
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (1500) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (BUSY_M !== 1'b1 || RD_M !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: busy=%b rd=%h expected 1 00000000", BUSY_M, RD_M);
    end
    @(negedge clk);
    reset = 1'b0;
    early_drop = 0;
    for (int i = 1; i <= 3072; i++) begin
      @(posedge clk);
      #1;
      if (i < 3072 && BUSY_M !== 1'b1) early_drop++;
      if (i == 100) begin
        INSTR_M  = {OP_SW, 26'h0};
        ALUOUT_M = 32'h10;
        A2_M     = 32'hCAFEBABE;
        $display("txn op=%h addr=%h a2=%h during sweep busy=%b", OP_SW, ALUOUT_M, A2_M, BUSY_M);
      end
      if (i == 101) INSTR_M = {OP_NOP, 26'h0};
      if (i == 3072) begin
        n_checks++;
        if (BUSY_M !== 1'b0) begin
          n_fail++;
          $display("FAIL resweep_end: busy=%b expected 0 at cycle 3072", BUSY_M);
        end
      end
    end
    n_checks++;
    if (early_drop != 0) begin
      n_fail++;
      $display("FAIL resweep_hold: busy low in %0d cycles expected 0", early_drop);
    end
    drive(OP_LW, 32'h10, 32'h0);
    n_checks++;
    if (RD_M !== 32'h0) begin
      n_fail++;
      $display("FAIL store_during_busy: rd=%h expected 00000000", RD_M);
    end
    drive(OP_LW, 32'h40, 32'h0);
    n_checks++;
    if (RD_M !== 32'h0) begin
      n_fail++;
      $display("FAIL resweep_cleared: rd=%h expected 00000000", RD_M);
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_merge();
    test_exceptions();
    test_trace_store();
    test_mid_sweep_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_dmem_unit.md
Name: m_dmem_unit

Overview:
Memory-stage data memory of the 5-stage MIPS pipeline. It consumes the E/M pipeline register outputs (INSTR_M, ALUOUT_M, A2_M, PC4_M), performs byte, halfword and word loads and stores against an internal word array, and returns extended load data to the M/W register. After reset it runs a hardware clear sweep and holds the pipeline with BUSY_M until the sweep finishes.

Parameters:
DEPTH_WORDS, 3072, number of 32-bit words; valid byte address range is 0 to 4*DEPTH_WORDS-1.
IDX_W, 12, word-index width; must satisfy 2^IDX_W >= DEPTH_WORDS.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
INSTR_M  input  32  M-stage instruction; opcode is INSTR_M[31:26].
ALUOUT_M  input  32  byte address.
A2_M  input  32  store data (rt value).
PC4_M  input  32  PC+4 of the M-stage instruction; used for trace only.
RD_M  output  32  load result, sign- or zero-extended.
BUSY_M  output  1  high while clear sweep runs; stalls F/D/E/M.
ADEXC_M  output  1  misaligned or out-of-range access by a load or store.

Behaviour:
- States: CLEAR, RUN. Asynchronous reset forces CLEAR and clr_idx=0. Outputs during reset: RD_M=0, BUSY_M=1, ADEXC_M=0.
- CLEAR: each cycle write 0 to mem[clr_idx] and increment clr_idx. When clr_idx==DEPTH_WORDS-1, write it and go to RUN on the same edge. The sweep takes exactly DEPTH_WORDS cycles after reset deasserts.
- In CLEAR: BUSY_M=1, RD_M=0, ADEXC_M=0, and all pipeline stores are ignored.
- A reset asserted mid-sweep restarts the sweep from index 0.
- Opcode decode:
  - Stores: sw 0x2B, sh 0x29, sb 0x28.
  - Loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - Any other opcode is a non-memory op: RD_M=0, ADEXC_M=0, no write.
- Address checks:
  - Word index is ALUOUT_M[IDX_W+1:2].
  - Misaligned: word access with addr[1:0]!=0, or halfword access with addr[0]!=0.
  - Out of range: addr >= 4*DEPTH_WORDS.
  - Either condition gives ADEXC_M=1 combinationally, RD_M=0 and the write is suppressed.
- Byte lanes are little-endian: byte k of a word sits at bits [8k+7:8k].
- Store byte enables:
  - sw: 4'b1111.
  - sh: 4'b0011 << (2*addr[1]).
  - sb: 4'b0001 << addr[1:0].
  - Data is replicated into the lanes (sh: {A2_M[15:0],A2_M[15:0]}; sb: four copies of A2_M[7:0]).
  - The write is merged into mem at posedge clk in RUN; unenabled bytes are preserved.
- Load read path:
  - The read is asynchronous (combinational) from mem[idx], so RD_M is valid in the same cycle.
  - lb/lh sign-extend the selected byte or half; lbu/lhu zero-extend.
- A store followed by a load to the same word on the next cycle returns the new data; no extra forwarding is needed.
- BUSY_M is registered from the state: it deasserts on the clock edge that enters RUN.

Optional Feature:
DM_TRACE_EN
- Defined: every committed store in RUN executes $display("%d@%h: *%h <= %h", $time, PC4_M-4, {ALUOUT_M[31:2],2'b00}, merged_word).
  - merged_word is the full post-merge 32-bit word.
  - Suppressed stores (ADEXC_M=1) and clear-sweep writes are not printed.
- Undefined: no simulation output; the logic is identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams (OP_SW, OP_SH, OP_SB, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU).
  - the dmem_state_t enum {CLEAR, RUN}.
  - the access-size enum {SZ_B, SZ_H, SZ_W}.
- One combinational sub-module, dm_lane_unit, takes size, signedness, addr[1:0], A2_M and the raw word. It produces byte enables, replicated store data and the extended load result.
- The top level holds the FSM, clear counter, array and address checks.

Test Plan:
- Reset, then hold 10 cycles → BUSY_M=1 throughout; deasserts exactly 3072 cycles after reset falls; lw from 0x2FFC returns 0.
- sw 0x12345678 to 0x0010, then lb 0x0011 / lbu 0x0013 / lh 0x0012 / lhu 0x0010 → 0x00000056 / 0x00000012 / 0x00001234 / 0x00005678.
- Preload 0x12345678 at 0x0020; sb A2_M=0x000000AB to 0x0021, then sh A2_M=0x0000CDEF to 0x0022, then lw → 0xCDEFAB78; lb 0x0021 → 0xFFFFFFAB.
- lw 0x0006, sh 0x0003, sw 0x3000 → ADEXC_M=1 and RD_M=0 for each; a following lw of the affected words shows the contents unchanged.
- Reset pulse asserted mid-sweep at cycle 1500 → sweep restarts; BUSY_M stays high until 3072 cycles after the second reset release; a sw during BUSY_M leaves memory unchanged.
- With DM_TRACE_EN and PC4_M=0x3004, sw 0xDEADBEEF to 0x0040 → one line "...@00003000: *00000040 <= deadbeef".
